// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master round-robin arbiter with burst lock and watchdog in front of mem_controller
module mem_bus_arbiter #(
    parameter int BURST_MAX = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [7:0]  m0_wdata,
    output logic [7:0]  m0_rdata,
    output logic        m0_ready,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [7:0]  m1_wdata,
    output logic [7:0]  m1_rdata,
    output logic        m1_ready,
    output logic        memRead,
    output logic        memWrite,
    output logic [31:0] memAddr,
    output logic [7:0]  memDataOut,
    input  logic [7:0]  memDataIn,
    input  logic        memReady,
    output logic [1:0]  grant,
    output logic        bus_timeout
);
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_t;

    localparam logic [7:0] WD_LAST   = 8'(TIMEOUT - 1);
    localparam logic [4:0] BURST_LIM = 5'(BURST_MAX);

    state_t      state;
    logic        last_owner;
    logic [3:0]  burst_cnt;
    logic [7:0]  wd_cnt;

    logic        req0, req1, own_req, oth_req, burst_ok, win_m1;
    logic        in_xfer, sel_read, sel_write, timeout_hit, xfer_end;
    logic [31:0] sel_addr;
    logic [7:0]  sel_wdata, rdata_mux;

    assign req0     = m0_read | m0_write;
    assign req1     = m1_read | m1_write;
    assign own_req  = grant[1] ? req1 : req0;
    assign oth_req  = grant[1] ? req0 : req1;
    assign burst_ok = ({1'b0, burst_cnt} + 5'd1) < BURST_LIM;
    // On a tie the master that did not own the bus last gets it.
    assign win_m1   = req1 & (~req0 | ~last_owner);

    assign sel_read  = grant[1] ? m1_read  : m0_read;
    assign sel_write = grant[1] ? m1_write : m0_write;
    assign sel_addr  = grant[1] ? m1_addr  : m0_addr;
    assign sel_wdata = grant[1] ? m1_wdata : m0_wdata;

    assign in_xfer     = (state == S_XFER);
    assign memRead     = in_xfer & sel_read;
    assign memWrite    = in_xfer & sel_write & ~sel_read;
    assign memAddr     = in_xfer ? sel_addr  : 32'd0;
    assign memDataOut  = in_xfer ? sel_wdata : 8'd0;

    assign timeout_hit = in_xfer & ~memReady & (wd_cnt == WD_LAST);
    assign xfer_end    = (in_xfer & memReady) | timeout_hit;
    assign rdata_mux   = memReady ? memDataIn : 8'hFF;
    assign bus_timeout = timeout_hit;

    assign m0_ready = xfer_end & grant[0];
    assign m1_ready = xfer_end & grant[1];
    assign m0_rdata = m0_ready ? rdata_mux : 8'd0;
    assign m1_rdata = m1_ready ? rdata_mux : 8'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            grant      <= 2'b00;
            last_owner <= 1'b1;
            burst_cnt  <= 4'd0;
            wd_cnt     <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    wd_cnt <= 8'd0;
                    if (req0 | req1) begin
                        grant <= win_m1 ? 2'b10 : 2'b01;
                        state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (xfer_end) begin
                        state <= S_GAP;
                    end else if (wd_cnt != 8'hFF) begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                S_GAP: begin
                    wd_cnt <= 8'd0;
                    if (own_req && !oth_req) begin
                        state <= S_XFER;
                    end else if (own_req && oth_req && burst_ok) begin
                        burst_cnt <= burst_cnt + 4'd1;
                        state     <= S_XFER;
                    end else if (oth_req) begin
                        grant      <= ~grant;
                        last_owner <= grant[1];
                        burst_cnt  <= 4'd0;
                        state      <= S_XFER;
                    end else begin
                        grant     <= 2'b00;
                        burst_cnt <= 4'd0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_addr, m1_addr, memAddr;
    logic [7:0]  m0_wdata, m1_wdata, m0_rdata, m1_rdata, memDataOut, memDataIn;
    logic        m0_ready, m1_ready, memRead, memWrite, memReady, bus_timeout;
    logic [1:0]  grant;

    typedef struct {
        int         m;
        logic [7:0] d;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         rdy_cnt0 = 0;
    int         rdy_cnt1 = 0;
    int         mem_lat = 1;
    int         mem_cnt = 0;
    logic [7:0] mem [logic [31:0]];

    mem_bus_arbiter #(.BURST_MAX(4), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .memRead(memRead), .memWrite(memWrite), .memAddr(memAddr), .memDataOut(memDataOut),
        .memDataIn(memDataIn), .memReady(memReady),
        .grant(grant), .bus_timeout(bus_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rd_val(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'h5C;
    endfunction

    // Memory responder: memReady rises on the mem_lat-th strobed cycle (0 = never).
    always @(posedge clk) begin
        #1;
        if ((memRead || memWrite) && !rst) begin
            mem_cnt = mem_cnt + 1;
            if (mem_lat != 0 && mem_cnt == mem_lat) begin
                memReady = 1'b1;
                if (memRead) begin
                    memDataIn = rd_val(memAddr);
                end else begin
                    memDataIn = 8'h00;
                    mem[memAddr] = memDataOut;
                end
            end else begin
                memReady  = 1'b0;
                memDataIn = 8'h00;
            end
        end else begin
            memReady  = 1'b0;
            memDataIn = 8'h00;
            mem_cnt   = 0;
        end
    end

    always @(negedge clk) begin
        if (m0_ready || m1_ready) begin
            int         m;
            logic [7:0] d;
            exp_t       e;
            m = m0_ready ? 0 : 1;
            d = m0_ready ? m0_rdata : m1_rdata;
            if (m0_ready) rdy_cnt0++;
            if (m1_ready) rdy_cnt1++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: m%0d ready with rdata %02h, required no completion", m, d);
            end else begin
                e = sb.pop_front();
                if (e.m != m || e.d !== d || (m0_ready && m1_ready) || (m0_ready ? m1_rdata : m0_rdata) !== 8'h00) begin
                    errors++;
                    $display("FAIL sb_completion: got m%0d rdata %02h (other rdata %02h), required m%0d rdata %02h",
                             m, d, m0_ready ? m1_rdata : m0_rdata, e.m, e.d);
                end
            end
        end
    end

    task automatic set_req(input int m, input logic rd, input logic wr, input logic [31:0] a, input logic [7:0] wd);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_addr = a; m0_wdata = wd;
        end else begin
            m1_read = rd; m1_write = wr; m1_addr = a; m1_wdata = wd;
        end
    endtask

    task automatic run_master(input int m, input int n, input logic wr, input logic [31:0] base, input logic [7:0] wd);
        for (int i = 0; i < n; i++) begin
            int cyc;
            set_req(m, !wr, wr, base + 32'(i), wd);
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!(m == 0 ? m0_ready : m1_ready) && cyc < 600);
            checks++;
            if (cyc >= 600) begin
                errors++;
                $display("FAIL m%0d_complete: no ready after %0d cycles, required fewer than 600", m, cyc);
            end
            @(posedge clk);
            #2;
        end
        set_req(m, 1'b0, 1'b0, 32'd0, 8'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 32'd0, 8'd0);
        set_req(1, 1'b0, 1'b0, 32'd0, 8'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 32'd0, 8'd0);
        set_req(1, 1'b0, 1'b0, 32'd0, 8'd0);
        #3;
        checks++;
        if (grant !== 2'b00 || {memRead, memWrite} !== 2'b00) begin
            errors++;
            $display("FAIL reset_grant: grant=%b rd/wr=%b%b, required 00 and 00", grant, memRead, memWrite);
        end
        checks++;
        if ({m0_ready, m1_ready, bus_timeout} !== 3'b000 || memAddr !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b%b timeout=%b addr=%h, required all zero",
                     m0_ready, m1_ready, bus_timeout, memAddr);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        int c0;
        do_reset();
        mem[32'h10] = 8'h5A;
        mem_lat = 3;
        c0 = rdy_cnt0;
        sb.push_back('{0, 8'h5A});
        set_req(0, 1'b1, 1'b0, 32'h10, 8'd0);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (grant !== 2'b01 || memRead !== 1'b1 || memAddr !== 32'h10) begin
            errors++;
            $display("FAIL single_grant: grant=%b memRead=%b addr=%h, required 01 1 00000010", grant, memRead, memAddr);
        end
        run_master(0, 1, 1'b0, 32'h10, 8'd0);
        repeat (3) @(negedge clk);
        checks++;
        if (grant !== 2'b00 || rdy_cnt0 - c0 != 1) begin
            errors++;
            $display("FAIL single_done: grant=%b ready pulses=%0d, required 00 and 1", grant, rdy_cnt0 - c0);
        end
    endtask

    task automatic test_tie();
        do_reset();
        mem_lat = 2;
        sb.push_back('{0, rd_val(32'h20)});
        sb.push_back('{1, rd_val(32'h30)});
        fork
            run_master(0, 1, 1'b0, 32'h20, 8'd0);
            run_master(1, 1, 1'b0, 32'h30, 8'd0);
            begin
                int cyc;
                @(posedge clk);
                @(negedge clk);
                checks++;
                if (grant !== 2'b01) begin
                    errors++;
                    $display("FAIL tie_first: grant=%b, required 01", grant);
                end
                cyc = 0;
                while (!m0_ready && cyc < 50) begin
                    @(negedge clk);
                    cyc++;
                end
                @(negedge clk);
                checks++;
                if ({memRead, memWrite} !== 2'b00 || grant !== 2'b01) begin
                    errors++;
                    $display("FAIL tie_gap: rd/wr=%b%b grant=%b, required 00 and 01", memRead, memWrite, grant);
                end
                @(negedge clk);
                checks++;
                if (grant !== 2'b10 || memRead !== 1'b1 || memAddr !== 32'h30) begin
                    errors++;
                    $display("FAIL tie_switch: grant=%b memRead=%b addr=%h, required 10 1 00000030", grant, memRead, memAddr);
                end
            end
        join
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem_lat = 2;
        mem[32'h800] = 8'h00;
        for (int i = 0; i < 4; i++) sb.push_back('{0, rd_val(32'h100 + 32'(i))});
        sb.push_back('{1, 8'h00});
        for (int i = 4; i < 6; i++) sb.push_back('{0, rd_val(32'h100 + 32'(i))});
        fork
            run_master(0, 6, 1'b0, 32'h100, 8'd0);
            run_master(1, 1, 1'b1, 32'h800, 8'h33);
        join
        checks++;
        if (mem[32'h800] !== 8'h33) begin
            errors++;
            $display("FAIL burst_write: mem[800]=%02h, required 33", mem[32'h800]);
        end
    endtask

    task automatic test_timeout();
        int cnt, seen;
        do_reset();
        mem_lat = 0;
        sb.push_back('{1, 8'hFF});
        set_req(1, 1'b0, 1'b1, 32'h40, 8'h77);
        cnt = 0;
        seen = 0;
        for (int c = 0; c < 400 && seen == 0; c++) begin
            @(negedge clk);
            if (memWrite) cnt++;
            if (bus_timeout) seen = 1;
        end
        checks++;
        if (seen != 1 || cnt != 255 || m1_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse: seen=%0d xfer cycles=%0d m1_ready=%b, required 1 255 1", seen, cnt, m1_ready);
        end
        @(posedge clk);
        #2;
        set_req(1, 1'b0, 1'b0, 32'd0, 8'd0);
        @(negedge clk);
        checks++;
        if (memWrite !== 1'b0 || bus_timeout !== 1'b0 || grant !== 2'b10) begin
            errors++;
            $display("FAIL timeout_gap: memWrite=%b timeout=%b grant=%b, required 0 0 10", memWrite, bus_timeout, grant);
        end
        @(negedge clk);
        checks++;
        if (grant !== 2'b00 || mem.exists(32'h40)) begin
            errors++;
            $display("FAIL timeout_idle: grant=%b written=%0d, required 00 0", grant, mem.exists(32'h40));
        end
    endtask

    task automatic test_read_write_both();
        int bad, seen_rd;
        do_reset();
        mem_lat = 2;
        sb.push_back('{0, rd_val(32'h55)});
        set_req(0, 1'b1, 1'b1, 32'h55, 8'h99);
        bad = 0;
        seen_rd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (memWrite) bad = 1;
            if (memRead) seen_rd = 1;
            if (m0_ready) break;
        end
        @(posedge clk);
        #2;
        set_req(0, 1'b0, 1'b0, 32'd0, 8'd0);
        checks++;
        if (bad != 0 || seen_rd != 1 || mem.exists(32'h55)) begin
            errors++;
            $display("FAIL rw_priority: memWrite seen=%0d memRead seen=%0d written=%0d, required 0 1 0",
                     bad, seen_rd, mem.exists(32'h55));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_lat = 0;
        set_req(0, 1'b1, 1'b0, 32'h66, 8'd0);
        repeat (3) @(negedge clk);
        checks++;
        if (memRead !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: memRead=%b, required 1", memRead);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({memRead, memWrite} !== 2'b00 || grant !== 2'b00 || m0_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: rd/wr=%b%b grant=%b ready=%b, required 00 00 0", memRead, memWrite, grant, m0_ready);
        end
        set_req(0, 1'b0, 1'b0, 32'd0, 8'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        mem_lat = 1;
        sb.push_back('{0, rd_val(32'h70)});
        sb.push_back('{1, rd_val(32'h71)});
        fork
            run_master(0, 1, 1'b0, 32'h70, 8'd0);
            run_master(1, 1, 1'b0, 32'h71, 8'd0);
            begin
                @(posedge clk);
                @(negedge clk);
                checks++;
                if (grant !== 2'b01) begin
                    errors++;
                    $display("FAIL midrst_arb: grant=%b, required 01", grant);
                end
            end
        join
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        memReady  = 1'b0;
        memDataIn = 8'h00;
        test_reset();
        test_single_read();
        test_tie();
        test_back_to_back();
        test_timeout();
        test_read_write_both();
        test_reset_mid();
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d completions outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
